// File: rtl/float_pkg.sv
// float_pkg: shared constants, class encoding and helpers for the float datapath blocks.
package float_pkg;

   localparam int FLOAT_WIDTH = 16;
   localparam int EXP_WIDTH   = 5;
   localparam int MANT_WIDTH  = 10;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      SUB  = 3'd1,
      NORM = 3'd2,
      INF  = 3'd3,
      NAN  = 3'd4
   } float_class_e;

   function automatic int exp_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // Positive quiet NaN: all-ones exponent with only the top fraction bit set.
   function automatic logic [63:0] canonical_nan(input int ew, input int mw);
      logic [63:0] one_v;
      one_v = 64'd1;
      return (((one_v << ew) - one_v) << mw) | (one_v << (mw - 1));
   endfunction

endpackage

// File: rtl/float_add_pipe_if.sv
// float_add_pipe_if: operand and result valid/ready channels of the pipelined float adder.
interface float_add_pipe_if
   import float_pkg::*;
#(
   parameter int float_width = FLOAT_WIDTH
);
   logic                   in_valid;
   logic                   in_ready;
   logic [float_width-1:0] float_a;
   logic [float_width-1:0] float_b;
   logic                   sub;
   logic                   out_valid;
   logic                   out_ready;
   logic [float_width-1:0] res;
   logic [3:0]             flags;

   modport master (
      output in_valid, float_a, float_b, sub, out_ready,
      input  in_ready, out_valid, res, flags
   );

   modport slave (
      input  in_valid, float_a, float_b, sub, out_ready,
      output in_ready, out_valid, res, flags
   );
endinterface

// File: rtl/float_norm_round.sv
// float_norm_round: normalise a raw significand sum, round to nearest-even and pack with flags.
// FLOAT_ADD_SUBNORMAL_EN selects gradual underflow; otherwise tiny results flush to signed zero.
module float_norm_round
   import float_pkg::*;
#(
   parameter int exponent_width = EXP_WIDTH,
   parameter int mantissa_width = MANT_WIDTH
) (
   input  logic                                   sign,
   input  logic [exponent_width-1:0]              exp_in,
   input  logic [mantissa_width+4:0]              sum,
   output logic [exponent_width+mantissa_width:0] res,
   output logic [3:0]                             flags
);
   localparam int EW  = exponent_width;
   localparam int MW  = mantissa_width;
   localparam int SW  = MW + 4;
   localparam int XEW = EW + 2;
   localparam int LZW = $clog2(SW + 1);
   localparam logic signed [XEW-1:0] EXP_ONE = XEW'(1);
   localparam logic signed [XEW-1:0] EXP_MAX = XEW'((1 << EW) - 1);

   logic [LZW-1:0]        lzc_s;
   logic signed [XEW-1:0] e_in_s;
   logic signed [XEW-1:0] lz_s;
   logic signed [XEW-1:0] sh_s;
   logic signed [XEW-1:0] e_n_s;
   logic signed [XEW-1:0] e_r_s;
   logic [SW-1:0]         mant_s;
   logic [MW:0]           keep_s;
   logic                  g_s;
   logic                  r_s;
   logic                  st_s;
   logic                  inexact_s;
   logic                  rnd_up_s;
   logic [MW+1:0]         rounded_s;
   logic [MW:0]           sig_f_s;
   logic                  tiny_s;

   // Leading-zero count below the carry bit; the highest set bit wins.
   always_comb begin
      lzc_s = LZW'(SW);
      for (int i = 0; i < SW; i++) begin
         lzc_s = sum[i] ? LZW'(SW - 1 - i) : lzc_s;
      end
   end

   // Normalise (1-bit right on carry, else left by lzc) and round to nearest, ties to even.
   always_comb begin
      e_in_s = $signed({2'b00, exp_in});
      lz_s   = $signed(XEW'(lzc_s));
      sh_s   = {XEW{1'b0}};
      if (sum[SW]) begin
         mant_s = {sum[SW:2], sum[1] | sum[0]};
         e_n_s  = e_in_s + EXP_ONE;
      end else begin
`ifdef FLOAT_ADD_SUBNORMAL_EN
         // Stop at exponent 1 so the result stays a correctly aligned subnormal.
         sh_s = (lz_s > (e_in_s - EXP_ONE)) ? (e_in_s - EXP_ONE) : lz_s;
`else
         sh_s = lz_s;
`endif
         mant_s = sum[SW-1:0] << sh_s;
         e_n_s  = e_in_s - sh_s;
      end
      keep_s    = mant_s[SW-1:3];
      g_s       = mant_s[2];
      r_s       = mant_s[1];
      st_s      = mant_s[0];
      inexact_s = g_s | r_s | st_s;
      rnd_up_s  = g_s & (r_s | st_s | keep_s[0]);
      rounded_s = {1'b0, keep_s} + {{(MW + 1){1'b0}}, rnd_up_s};
      if (rounded_s[MW+1]) begin
         sig_f_s = rounded_s[MW+1:1];
         e_r_s   = e_n_s + EXP_ONE;
      end else begin
         sig_f_s = rounded_s[MW:0];
         e_r_s   = e_n_s;
      end
      tiny_s = ~mant_s[SW-1];
   end

   // Pick zero, overflow, flushed or ordinary packing.
   always_comb begin
      res   = {(EW + MW + 1){1'b0}};
      flags = 4'b0000;
      if (sum == {(SW + 1){1'b0}}) begin
         res = {sign, {(EW + MW){1'b0}}};
      end else if (e_r_s >= EXP_MAX) begin
         res                  = {sign, {EW{1'b1}}, {MW{1'b0}}};
         flags[FLAG_OVERFLOW] = 1'b1;
         flags[FLAG_INEXACT]  = 1'b1;
`ifdef FLOAT_ADD_SUBNORMAL_EN
      end else begin
         res                   = {sign, (sig_f_s[MW] ? e_r_s[EW-1:0] : {EW{1'b0}}), sig_f_s[MW-1:0]};
         flags[FLAG_UNDERFLOW] = tiny_s & inexact_s;
         flags[FLAG_INEXACT]   = inexact_s;
      end
`else
      end else if ((e_n_s < EXP_ONE) || tiny_s) begin
         res                   = {sign, {(EW + MW){1'b0}}};
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end else begin
         res                 = {sign, (sig_f_s[MW] ? e_r_s[EW-1:0] : {EW{1'b0}}), sig_f_s[MW-1:0]};
         flags[FLAG_INEXACT] = inexact_s;
      end
`endif
   end

endmodule

// File: rtl/float_add_pipe.sv
// float_add_pipe: three-stage float adder/subtractor (unpack/align, add, normalise/round) with a global stall.
// Define FLOAT_ADD_SUBNORMAL_EN for subnormal support; otherwise subnormals flush to zero.
module float_add_pipe
   import float_pkg::*;
#(
   parameter int float_width    = FLOAT_WIDTH,
   parameter int exponent_width = EXP_WIDTH,
   parameter int mantissa_width = MANT_WIDTH
) (
   input logic             clk,
   input logic             rst,
   float_add_pipe_if.slave bus
);
   localparam int EW = exponent_width;
   localparam int MW = mantissa_width;
   localparam int SW = MW + 4;
   localparam int XW = MW + 5;
   localparam logic [63:0]            NAN64  = canonical_nan(EW, MW);
   localparam logic [float_width-1:0] QNAN   = NAN64[float_width-1:0];
   localparam logic [EW-1:0]          SH_MAX = EW'(MW + 3);

   function automatic float_class_e classify(input logic [EW-1:0] e, input logic [MW-1:0] f);
      float_class_e c;
      if (e == {EW{1'b1}}) begin
         c = (f == {MW{1'b0}}) ? INF : NAN;
      end else if (e == {EW{1'b0}}) begin
         c = (f == {MW{1'b0}}) ? ZERO : SUB;
      end else begin
         c = NORM;
      end
      return c;
   endfunction

   // Working exponent and {hidden, fraction, G, R, S}; zeros sit at exponent 1 with empty significand.
   function automatic logic [EW+SW-1:0] expand(input float_class_e c, input logic [EW-1:0] e,
                                               input logic [MW-1:0] f);
      logic [EW+SW-1:0] x;
      case (c)
         NORM:    x = {e, 1'b1, f, 3'b000};
`ifdef FLOAT_ADD_SUBNORMAL_EN
         SUB:     x = {EW'(1), 1'b0, f, 3'b000};
`endif
         default: x = {EW'(1), {SW{1'b0}}};
      endcase
      return x;
   endfunction

   logic                   adv_s;
   logic                   sa_s, sb_s, a_ge_s, sign1_s, spec1_s, sign2_s;
   float_class_e           ca_s, cb_s;
   logic [EW-1:0]          ea_s, eb_s, el_s, es_s, diff_s, sh_s;
   logic [SW-1:0]          ma_s, mb_s, ml_s, ms_s, ms_sh_s, lost_s;
   logic [float_width-1:0] spec_res1_s, nr_res_s;
   logic [3:0]             spec_flags1_s, nr_flags_s;
   logic [XW-1:0]          sum_s;

   logic                   v1_r, sign1_r, eff_sub1_r, spec1_r;
   logic [EW-1:0]          exp1_r;
   logic [SW-1:0]          big1_r, small1_r;
   logic [float_width-1:0] spec_res1_r;
   logic [3:0]             spec_flags1_r;
   logic                   v2_r, sign2_r, spec2_r;
   logic [EW-1:0]          exp2_r;
   logic [XW-1:0]          sum2_r;
   logic [float_width-1:0] spec_res2_r;
   logic [3:0]             spec_flags2_r;

   assign adv_s        = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv_s;

   // Stage 1: classify, resolve specials, order by magnitude and align the smaller significand.
   always_comb begin
      sa_s = bus.float_a[float_width-1];
      sb_s = bus.float_b[float_width-1] ^ bus.sub;
      ca_s = classify(bus.float_a[float_width-2:MW], bus.float_a[MW-1:0]);
      cb_s = classify(bus.float_b[float_width-2:MW], bus.float_b[MW-1:0]);
      {ea_s, ma_s} = expand(ca_s, bus.float_a[float_width-2:MW], bus.float_a[MW-1:0]);
      {eb_s, mb_s} = expand(cb_s, bus.float_b[float_width-2:MW], bus.float_b[MW-1:0]);
      a_ge_s = {ea_s, ma_s} >= {eb_s, mb_s};
      if (a_ge_s) begin
         sign1_s = sa_s;
         el_s    = ea_s;
         ml_s    = ma_s;
         es_s    = eb_s;
         ms_s    = mb_s;
      end else begin
         sign1_s = sb_s;
         el_s    = eb_s;
         ml_s    = mb_s;
         es_s    = ea_s;
         ms_s    = ma_s;
      end
      diff_s  = el_s - es_s;
      sh_s    = (diff_s > SH_MAX) ? SH_MAX : diff_s;
      ms_sh_s = ms_s >> sh_s;
      lost_s  = ms_s & ~({SW{1'b1}} << sh_s);
      if ((ca_s == NAN) || (cb_s == NAN) || ((ca_s == INF) && (cb_s == INF) && (sa_s != sb_s))) begin
         spec1_s                     = 1'b1;
         spec_res1_s                 = QNAN;
         spec_flags1_s               = 4'b0000;
         spec_flags1_s[FLAG_INVALID] = 1'b1;
      end else if (ca_s == INF) begin
         spec1_s       = 1'b1;
         spec_res1_s   = {sa_s, {EW{1'b1}}, {MW{1'b0}}};
         spec_flags1_s = 4'b0000;
      end else if (cb_s == INF) begin
         spec1_s       = 1'b1;
         spec_res1_s   = {sb_s, {EW{1'b1}}, {MW{1'b0}}};
         spec_flags1_s = 4'b0000;
      end else begin
         spec1_s       = 1'b0;
         spec_res1_s   = {float_width{1'b0}};
         spec_flags1_s = 4'b0000;
      end
   end

   // Stage 2: magnitude add or subtract; an exact cancellation is always +0.
   always_comb begin
      if (eff_sub1_r) begin
         sum_s = {1'b0, big1_r} - {1'b0, small1_r};
      end else begin
         sum_s = {1'b0, big1_r} + {1'b0, small1_r};
      end
      sign2_s = (eff_sub1_r && (sum_s == {XW{1'b0}})) ? 1'b0 : sign1_r;
   end

   float_norm_round #(
      .exponent_width (EW),
      .mantissa_width (MW)
   ) u_norm_round (
      .sign   (sign2_r),
      .exp_in (exp2_r),
      .sum    (sum2_r),
      .res    (nr_res_s),
      .flags  (nr_flags_s)
   );

   // Pipeline registers; every stage moves together whenever the output slot can take a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r          <= 1'b0;
         sign1_r       <= 1'b0;
         eff_sub1_r    <= 1'b0;
         spec1_r       <= 1'b0;
         exp1_r        <= {EW{1'b0}};
         big1_r        <= {SW{1'b0}};
         small1_r      <= {SW{1'b0}};
         spec_res1_r   <= {float_width{1'b0}};
         spec_flags1_r <= 4'b0000;
         v2_r          <= 1'b0;
         sign2_r       <= 1'b0;
         spec2_r       <= 1'b0;
         exp2_r        <= {EW{1'b0}};
         sum2_r        <= {XW{1'b0}};
         spec_res2_r   <= {float_width{1'b0}};
         spec_flags2_r <= 4'b0000;
         bus.out_valid <= 1'b0;
         bus.res       <= {float_width{1'b0}};
         bus.flags     <= 4'b0000;
      end else if (adv_s) begin
         v1_r          <= bus.in_valid;
         sign1_r       <= sign1_s;
         eff_sub1_r    <= sa_s ^ sb_s;
         spec1_r       <= spec1_s;
         exp1_r        <= el_s;
         big1_r        <= ml_s;
         small1_r      <= {ms_sh_s[SW-1:1], ms_sh_s[0] | (|lost_s)};
         spec_res1_r   <= spec_res1_s;
         spec_flags1_r <= spec_flags1_s;
         v2_r          <= v1_r;
         sign2_r       <= sign2_s;
         spec2_r       <= spec1_r;
         exp2_r        <= exp1_r;
         sum2_r        <= sum_s;
         spec_res2_r   <= spec_res1_r;
         spec_flags2_r <= spec_flags1_r;
         bus.out_valid <= v2_r;
         bus.res       <= spec2_r ? spec_res2_r : nr_res_s;
         bus.flags     <= spec2_r ? spec_flags2_r : nr_flags_s;
      end
   end

endmodule

// File: tb/tb_float_add_pipe.sv
// tb_float_add_pipe: directed vectors for float_add_pipe with a queue scoreboard and a separate monitor.
// Honours FLOAT_ADD_SUBNORMAL_EN for the subnormal vector.
module tb_float_add_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   float_add_pipe_if #(.float_width(16)) bus ();

   float_add_pipe #(
      .float_width    (16),
      .exponent_width (5),
      .mantissa_width (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flags;
      int          acc;
      bit          lat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   n_acc  = 0;
   int   stale  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Offer one operation; the expectation is queued at the cycle the handshake completes.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] r, input logic [3:0] f, input bit lat, input string name);
      exp_t e;
      int   waited;
      waited       = 0;
      bus.in_valid = 1'b1;
      bus.float_a  = a;
      bus.float_b  = b;
      bus.sub      = s;
      @(negedge clk);
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout in_ready %b want 1", name, bus.in_ready);
      end else begin
         e.res   = r;
         e.flags = f;
         e.acc   = cyc;
         e.lat   = lat;
         e.name  = name;
         exp_q.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every delivered result is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result got res %h flags %b want none", bus.res, bus.flags);
         end else begin
            e = exp_q.pop_front();
            check({e.name, "_res"}, 32'(bus.res), 32'(e.res));
            check({e.name, "_flags"}, 32'(bus.flags), 32'(e.flags));
            if (e.lat) check({e.name, "_latency"}, 32'(cyc - e.acc), 32'd3);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.float_a   = 16'h0000;
      bus.float_b   = 16'h0000;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_res", 32'(bus.res), 32'd0);
      check("reset_flags", 32'(bus.flags), 32'd0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      send(16'h34CD, 16'h3266, 1'b0, 16'h3800, 4'b0000, 1'b1, "add_0p3_0p2");
      wait_drain("t1");

      send(16'h34CD, 16'h34CD, 1'b0, 16'h38CD, 4'b0000, 1'b1, "add_0p3_0p3");
      send(16'h6108, 16'hF103, 1'b0, 16'hF0B2, 4'b0001, 1'b1, "tie_even");
      send(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000, 1'b1, "sub_equal");
      send(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, 1'b1, "overflow");
      send(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000, 1'b1, "inf_clash");
      send(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000, 1'b1, "nan_in");
      send(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000, 1'b1, "negzero_sum");
      send(16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b1, "mixed_zero");
      send(16'h4500, 16'h3C00, 1'b1, 16'h4400, 4'b0000, 1'b1, "five_minus_one");
      wait_drain("stream");

      bus.out_ready = 1'b0;
      n_acc         = 0;
      fork
         begin
            send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 1'b0, "bp0");
            send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000, 1'b0, "bp1");
            send(16'h4000, 16'h4000, 1'b0, 16'h4400, 4'b0000, 1'b0, "bp2");
            send(16'h4400, 16'h3C00, 1'b0, 16'h4500, 4'b0000, 1'b0, "bp3");
            send(16'h4500, 16'h3C00, 1'b1, 16'h4400, 4'b0000, 1'b0, "bp4");
         end
         begin
            repeat (8) @(negedge clk);
            check("bp_accepts", 32'(n_acc), 32'd3);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_res", 32'(bus.res), 32'h4000);
            repeat (3) @(negedge clk);
            check("bp_res_stable", 32'(bus.res), 32'h4000);
            check("bp_flags_stable", 32'(bus.flags), 32'd0);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      wait_drain("backpressure");
      check("bp_total_accepts", 32'(n_acc), 32'd5);

      send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, 1'b0, "rst_op0");
      send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000, 1'b0, "rst_op1");
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      check("rst_no_stale", 32'(stale), 32'd0);
      @(posedge clk);
      #1;

`ifdef FLOAT_ADD_SUBNORMAL_EN
      send(16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 1'b1, "subnormal_add");
`else
      send(16'h0001, 16'h0001, 1'b0, 16'h0000, 4'b0000, 1'b1, "subnormal_ftz");
`endif
      wait_drain("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
